// File: rtl/sdram_arbiter_if.sv
// Command-bus bundle between the SDRAM sub-modules (init, refresh, write, read) and the arbiter.
// master = sub-module side, slave = arbiter side that owns the physical pins.
interface sdram_arbiter_if;
   logic [3:0]  init_cmd;
   logic [11:0] init_addr;
   logic        flag_init_end;
   logic        ref_req;
   logic [3:0]  ref_cmd;
   logic [11:0] ref_addr;
   logic        flag_ref_end;
   logic        wr_req;
   logic [3:0]  wr_cmd;
   logic [11:0] wr_addr;
   logic [1:0]  wr_bank;
   logic [15:0] wr_data;
   logic        flag_wr_end;
   logic        rd_req;
   logic [3:0]  rd_cmd;
   logic [11:0] rd_addr;
   logic [1:0]  rd_bank;
   logic        flag_rd_end;
   logic        ref_en;
   logic        wr_en;
   logic        rd_en;
   logic        sdram_cke;
   logic        sdram_cs_n;
   logic        sdram_ras_n;
   logic        sdram_cas_n;
   logic        sdram_we_n;
   logic [1:0]  sdram_bank;
   logic [11:0] sdram_addr;
   logic [15:0] sdram_dq_out;
   logic        sdram_dq_oe;

   modport master (
      output init_cmd, init_addr, flag_init_end,
      output ref_req, ref_cmd, ref_addr, flag_ref_end,
      output wr_req, wr_cmd, wr_addr, wr_bank, wr_data, flag_wr_end,
      output rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
      input  ref_en, wr_en, rd_en,
      input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      input  sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
   );

   modport slave (
      input  init_cmd, init_addr, flag_init_end,
      input  ref_req, ref_cmd, ref_addr, flag_ref_end,
      input  wr_req, wr_cmd, wr_addr, wr_bank, wr_data, flag_wr_end,
      input  rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
      output ref_en, wr_en, rd_en,
      output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      output sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe
   );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: refresh > write > read, registered pin mux.
// Define SDRAM_ARB_RR_EN to alternate write/read when both request at once.
module sdram_arbiter (
   input  logic           sclk,
   input  logic           s_rst,
   sdram_arbiter_if.slave bus
);
   typedef enum logic [4:0] {
      StInit  = 5'b00001,
      StArbit = 5'b00010,
      StAref  = 5'b00100,
      StWrite = 5'b01000,
      StRead  = 5'b10000
   } state_e;

   localparam logic [3:0] CmdNop = 4'b0111;

   state_e      state_q, state_d;
   logic [3:0]  cmd_mux;
   logic [11:0] addr_mux;
   logic [1:0]  bank_mux;
   logic        pick_wr;

`ifdef SDRAM_ARB_RR_EN
   // 1 = write was granted most recently; reset means read went last.
   logic last_wr_q;

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         last_wr_q <= 1'b0;
      end else if (state_q == StArbit && state_d == StWrite) begin
         last_wr_q <= 1'b1;
      end else if (state_q == StArbit && state_d == StRead) begin
         last_wr_q <= 1'b0;
      end
   end

   assign pick_wr = bus.wr_req && !(bus.rd_req && last_wr_q);
`else
   assign pick_wr = bus.wr_req;
`endif

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit:  if (bus.flag_init_end) state_d = StArbit;
         StArbit: begin
            if (bus.ref_req)      state_d = StAref;
            else if (pick_wr)     state_d = StWrite;
            else if (bus.rd_req)  state_d = StRead;
         end
         StAref:  if (bus.flag_ref_end) state_d = StArbit;
         StWrite: if (bus.flag_wr_end)  state_d = StArbit;
         StRead:  if (bus.flag_rd_end)  state_d = StArbit;
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      cmd_mux  = CmdNop;
      addr_mux = 12'h000;
      bank_mux = 2'b00;
      unique case (state_q)
         StInit: begin
            cmd_mux  = bus.init_cmd;
            addr_mux = bus.init_addr;
         end
         StAref: begin
            cmd_mux  = bus.ref_cmd;
            addr_mux = bus.ref_addr;
         end
         StWrite: begin
            cmd_mux  = bus.wr_cmd;
            addr_mux = bus.wr_addr;
            bank_mux = bus.wr_bank;
         end
         StRead: begin
            cmd_mux  = bus.rd_cmd;
            addr_mux = bus.rd_addr;
            bank_mux = bus.rd_bank;
         end
         default: ;
      endcase
   end

   assign bus.ref_en = (state_q == StAref);
   assign bus.wr_en  = (state_q == StWrite);
   assign bus.rd_en  = (state_q == StRead);

   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         bus.sdram_cke    <= 1'b0;
         bus.sdram_cs_n   <= CmdNop[3];
         bus.sdram_ras_n  <= CmdNop[2];
         bus.sdram_cas_n  <= CmdNop[1];
         bus.sdram_we_n   <= CmdNop[0];
         bus.sdram_bank   <= 2'b00;
         bus.sdram_addr   <= 12'h000;
         bus.sdram_dq_out <= 16'h0000;
         bus.sdram_dq_oe  <= 1'b0;
      end else begin
         bus.sdram_cke    <= 1'b1;
         bus.sdram_cs_n   <= cmd_mux[3];
         bus.sdram_ras_n  <= cmd_mux[2];
         bus.sdram_cas_n  <= cmd_mux[1];
         bus.sdram_we_n   <= cmd_mux[0];
         bus.sdram_bank   <= bank_mux;
         bus.sdram_addr   <= addr_mux;
         bus.sdram_dq_out <= bus.wr_data;
         bus.sdram_dq_oe  <= (state_q == StWrite);
      end
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: each driven cycle queues the expected grants and pins
// for the following cycle; a negedge monitor pops and compares them.
module tb_sdram_arbiter;
   typedef enum int {TInit, TArbit, TAref, TWrite, TRead} tb_st_e;

   typedef struct {
      int          due;
      string       tag;
      logic [39:0] exp;
   } sb_item_t;

   logic sclk;
   logic s_rst;
   int   cyc;
   int   n_checks;
   int   n_fail;
   sb_item_t sb[$];
   tb_st_e cur_st;

   sdram_arbiter_if bus ();

   sdram_arbiter dut (
      .sclk  (sclk),
      .s_rst (s_rst),
      .bus   (bus)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   initial cyc = 0;
   always @(posedge sclk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] observe();
      return {1'b0, bus.sdram_dq_out, bus.sdram_dq_oe, bus.ref_en, bus.wr_en, bus.rd_en,
              bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
              bus.sdram_bank, bus.sdram_addr};
   endfunction

   // Pins come from the bus owned in the current cycle; grants from the expected next owner.
   function automatic logic [39:0] expect_vec(input tb_st_e cur, input tb_st_e nxt);
      logic [3:0]  c;
      logic [1:0]  b;
      logic [11:0] a;
      c = 4'b0111;
      b = 2'b00;
      a = 12'h000;
      case (cur)
         TInit:  begin c = bus.init_cmd; a = bus.init_addr; end
         TAref:  begin c = bus.ref_cmd;  a = bus.ref_addr;  end
         TWrite: begin c = bus.wr_cmd;   a = bus.wr_addr;   b = bus.wr_bank; end
         TRead:  begin c = bus.rd_cmd;   a = bus.rd_addr;   b = bus.rd_bank; end
         default: ;
      endcase
      return {1'b0, bus.wr_data, cur == TWrite, nxt == TAref, nxt == TWrite, nxt == TRead,
              1'b1, c, b, a};
   endfunction

   localparam logic [39:0] ResetVec = {1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 4'b0111, 2'b00, 12'h000};

   always @(negedge sclk) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
         sb_item_t it;
         it = sb.pop_front();
         check_eq(it.tag, observe(), it.exp);
      end
   end

   task automatic step(input string tag, input tb_st_e nxt);
      sb_item_t it;
      it.due = cyc + 1;
      it.tag = tag;
      it.exp = expect_vec(cur_st, nxt);
      sb.push_back(it);
      @(posedge sclk);
      #1;
      cur_st = nxt;
      bus.flag_init_end = 1'b0;
      bus.flag_ref_end  = 1'b0;
      bus.flag_wr_end   = 1'b0;
      bus.flag_rd_end   = 1'b0;
   endtask

   task automatic tenure(input tb_st_e who);
      step("grant", who);
      step("hold", who);
      if (who == TWrite) bus.flag_wr_end = 1'b1;
      else               bus.flag_rd_end = 1'b1;
      step("release", TArbit);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cur_st   = TInit;
      s_rst    = 1'b1;
      bus.init_cmd = 4'b0111; bus.init_addr = 12'h000; bus.flag_init_end = 1'b0;
      bus.ref_req = 1'b0; bus.ref_cmd = 4'b0001; bus.ref_addr = 12'h000; bus.flag_ref_end = 1'b0;
      bus.wr_req = 1'b0; bus.wr_cmd = 4'b0100; bus.wr_addr = 12'h005; bus.wr_bank = 2'b10;
      bus.wr_data = 16'h1234; bus.flag_wr_end = 1'b0;
      bus.rd_req = 1'b0; bus.rd_cmd = 4'b0101; bus.rd_addr = 12'h0a7; bus.rd_bank = 2'b01;
      bus.flag_rd_end = 1'b0;

      @(posedge sclk); #1;
      check_eq("reset", observe(), ResetVec);
      @(posedge sclk); #1;
      s_rst = 1'b0;

      // Init phase; PRECHARGE and init end at cycle 10.
      for (int i = 0; i < 9; i++) begin
         bus.init_addr = 12'(i);
         step("init", TInit);
      end
      bus.init_cmd = 4'b0010; bus.init_addr = 12'h400; bus.flag_init_end = 1'b1;
      step("init_end", TArbit);
      bus.init_cmd = 4'b0111;
      step("arbit_idle", TArbit);
      bus.flag_wr_end = 1'b1;
      step("stray_flag", TArbit);

      // Single write tenure, with a foreign end flag ignored mid-tenure.
      bus.wr_req = 1'b1;
      step("wr_grant", TWrite);
      bus.wr_req = 1'b0; bus.wr_data = 16'hbeef;
      step("wr_cmd", TWrite);
      bus.wr_cmd = 4'b0111; bus.flag_rd_end = 1'b1; bus.flag_ref_end = 1'b1;
      step("wr_foreign_flag", TWrite);
      bus.flag_wr_end = 1'b1;
      step("wr_release", TArbit);
      step("wr_gap", TArbit);

      // All three request together: refresh, then write, then read.
      bus.ref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
      bus.wr_cmd = 4'b0100; bus.wr_addr = 12'h3c1; bus.wr_data = 16'h5a5a;
      step("all_ref", TAref);
      bus.ref_cmd = 4'b0001; bus.ref_addr = 12'h001;
      step("ref_hold", TAref);
      bus.flag_ref_end = 1'b1; bus.ref_req = 1'b0;
      step("ref_release", TArbit);
      step("all_wr", TWrite);
      step("wr_hold", TWrite);
      bus.flag_wr_end = 1'b1; bus.wr_req = 1'b0;
      step("wr_release2", TArbit);
      step("all_rd", TRead);
      bus.rd_addr = 12'h0ff; bus.rd_bank = 2'b11;
      step("rd_hold", TRead);
      bus.flag_rd_end = 1'b1; bus.rd_req = 1'b0;
      step("rd_release", TArbit);
      step("idle", TArbit);

      // Write yields to refresh and then regains the bus.
      bus.wr_req = 1'b1; bus.wr_bank = 2'b01;
      step("y_wr", TWrite);
      step("y_wr_hold", TWrite);
      bus.ref_req = 1'b1;
      step("y_ref_pending", TWrite);
      bus.flag_wr_end = 1'b1;
      step("y_wr_yield", TArbit);
      step("y_ref", TAref);
      bus.flag_ref_end = 1'b1; bus.ref_req = 1'b0;
      step("y_ref_release", TArbit);
      step("y_wr_again", TWrite);
      bus.flag_wr_end = 1'b1; bus.wr_req = 1'b0;
      step("y_wr_release", TArbit);

      // Write and read both held; write went last.
      bus.wr_req = 1'b1; bus.rd_req = 1'b1;
`ifdef SDRAM_ARB_RR_EN
      tenure(TRead);
      tenure(TWrite);
      tenure(TRead);
`else
      tenure(TWrite);
      tenure(TWrite);
      tenure(TWrite);
`endif

      // Reset in the middle of a read tenure.
      bus.wr_req = 1'b0;
      step("r_rd", TRead);
      step("r_rd_hold", TRead);
      @(negedge sclk); #1;
      s_rst = 1'b1;
      #1;
      check_eq("reset_mid_read", observe(), ResetVec);
      @(posedge sclk); #1;
      check_eq("reset_hold", observe(), ResetVec);
      s_rst = 1'b0;
      cur_st = TInit;
      bus.rd_req = 1'b0;
      step("reinit", TInit);
      bus.init_cmd = 4'b0010; bus.init_addr = 12'h400; bus.flag_init_end = 1'b1;
      step("reinit_end", TArbit);
      step("reinit_idle", TArbit);

      repeat (2) @(posedge sclk);
      #1;
      check_eq("sb_drain", 40'(sb.size()), 40'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
